// File: rtl/step_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : step_sequencer_if                                               |
// | Purpose  : Bundles the run-control, completion and status signals of the   |
// |            step sequencer.                                                 |
// | Modports : master - the controller: drives start, max_count,               |
// |                     timeout_cycles, ch_en and done; observes status.       |
// |            slave  - the sequencer: observes the controls and drives step,  |
// |                     busy, finish, instr_count, timeout_flag, timeout_cnt.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface step_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int N_CH  = 4,
  parameter int TO_W  = 8
);
  logic             start;
  logic [CNT_W-1:0] max_count;
  logic [TO_W-1:0]  timeout_cycles;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  done;
  logic             step;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] instr_count;
  logic             timeout_flag;
  logic [TO_W-1:0]  timeout_cnt;

  modport master (
    output start, max_count, timeout_cycles, ch_en, done,
    input  step, busy, finish, instr_count, timeout_flag, timeout_cnt
  );

  modport slave (
    input  start, max_count, timeout_cycles, ch_en, done,
    output step, busy, finish, instr_count, timeout_flag, timeout_cnt
  );
endinterface
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : step_sequencer                                                  |
// | Purpose  : Issues one PULSE_LEN-cycle step pulse per instruction, waits    |
// |            for every enabled execution unit to report done (or for a      |
// |            timeout), counts instructions and halts at a programmed count. |
// | Ports    : clk    - rising-edge clock                                      |
// |            rst_n  - asynchronous active-low reset                          |
// |            seq_if - step_sequencer_if.slave: start/max_count/             |
// |                     timeout_cycles/ch_en/done in; step/busy/finish/        |
// |                     instr_count/timeout_flag/timeout_cnt out               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module step_sequencer #(
  parameter int CNT_W     = 32,
  parameter int N_CH      = 4,
  parameter int TO_W      = 8,
  parameter int PULSE_LEN = 6,
  parameter int MIN_GAP   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  step_sequencer_if.slave    seq_if
);

  // Pulse counter must hold PULSE_LEN-1; wait counter must reach both
  // MIN_GAP and the largest timeout value, with one spare bit so the
  // saturating count can never sit below either threshold.
  localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int MG_W = $clog2(MIN_GAP + 1);
  localparam int W_W  = ((TO_W > MG_W) ? TO_W : MG_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [W_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [N_CH-1:0]  ch_en_q, ch_en_d;
  logic [N_CH-1:0]  seen_q, seen_d;
  logic             flag_q, flag_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             step_q;

  logic [W_W:0]     w_p1;
  logic             ready;
  logic             timeout;
  logic             wait_exit;

  // Completion arriving in the same cycle as the check counts immediately,
  // so a done coincident with the timeout threshold is treated as ready.
  assign w_p1      = {1'b0, wait_cnt_q} + (W_W + 1)'(1);
  assign ready     = ((seen_q | (seq_if.done & ch_en_q)) == ch_en_q);
  assign timeout   = (to_q != '0) && !ready && (w_p1 >= (W_W + 1)'(to_q));
  assign wait_exit = (w_p1 >= (W_W + 1)'(MIN_GAP)) && (ready || timeout);

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    instr_d     = instr_q;
    max_d       = max_q;
    to_d        = to_q;
    ch_en_d     = ch_en_q;
    seen_d      = seen_q;
    flag_d      = flag_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (seq_if.start) begin
          max_d       = seq_if.max_count;
          to_d        = seq_if.timeout_cycles;
          ch_en_d     = seq_if.ch_en;
          instr_d     = '0;
          flag_d      = 1'b0;
          to_cnt_d    = '0;
          pulse_cnt_d = '0;
          state_d     = (seq_if.max_count != '0) ? S_STEP : S_HALT;
        end
      end

      S_STEP: begin
        if (pulse_cnt_q == '0) begin
          // First cycle of the pulse: count the instruction and restart
          // completion tracking with whatever is already arriving.
          instr_d = instr_q + CNT_W'(1);
          seen_d  = seq_if.done & ch_en_q;
        end else begin
          seen_d  = seen_q | (seq_if.done & ch_en_q);
        end
        if (pulse_cnt_q == PC_W'(PULSE_LEN - 1)) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end
      end

      S_WAIT: begin
        seen_d = seen_q | (seq_if.done & ch_en_q);
        if (wait_exit) begin
          if (timeout) begin
            flag_d = 1'b1;
            if (to_cnt_q != '1) begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
          pulse_cnt_d = '0;
          state_d     = (instr_q >= max_q) ? S_HALT : S_STEP;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + W_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      instr_q     <= '0;
      max_q       <= '0;
      to_q        <= '0;
      ch_en_q     <= '0;
      seen_q      <= '0;
      flag_q      <= 1'b0;
      to_cnt_q    <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_q     <= instr_d;
      max_q       <= max_d;
      to_q        <= to_d;
      ch_en_q     <= ch_en_d;
      seen_q      <= seen_d;
      flag_q      <= flag_d;
      to_cnt_q    <= to_cnt_d;
      // Registered copy of "in STEP" so the pulse is glitch-free.
      step_q      <= (state_d == S_STEP);
    end
  end

  assign seq_if.step         = step_q;
  assign seq_if.busy         = (state_q == S_STEP) || (state_q == S_WAIT);
  assign seq_if.finish       = (state_q == S_HALT);
  assign seq_if.instr_count  = instr_q;
  assign seq_if.timeout_flag = flag_q;
  assign seq_if.timeout_cnt  = to_cnt_q;

endmodule
`default_nettype wire
